// File: rtl/dds_pport_pkg.sv
// Shared definitions for the DDS parallel-port responder and host sequencer.
// Control-bit positions here fix how host pins are packed into the synchronizer.
package dds_pport_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StTail
  } pport_state_e;

  // FTW byte offsets from FTW_BASE, most significant byte first.
  localparam int unsigned FtwOff31 = 0;
  localparam int unsigned FtwOff23 = 1;
  localparam int unsigned FtwOff15 = 2;
  localparam int unsigned FtwOff7  = 3;

  // Control synchronizer lanes. CSB is carried inverted, so its rising edge is a CSB fall.
  localparam int unsigned CtrlW      = 5;
  localparam int unsigned CtrlCsbn   = 0;
  localparam int unsigned CtrlRwn    = 1;
  localparam int unsigned CtrlPclk   = 2;
  localparam int unsigned CtrlUpd    = 3;
  localparam int unsigned CtrlDdsRst = 4;

  // Reset treats CSB as already low, so a frame left open across reset cannot start.
  localparam logic [CtrlW-1:0] CtrlRstVal = 5'b00001;

endpackage

// File: rtl/dds_pport_sync.sv
// Multi-bit flop-chain synchronizer with a registered copy for rising-edge detect.
module dds_pport_sync #(
  parameter int unsigned      Width    = 1,
  parameter int unsigned      Stages   = 2,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q,
  output logic [Width-1:0] rise
);

  localparam int unsigned ChainW = Stages * Width;

  logic [ChainW-1:0] chain_q;
  logic [Width-1:0]  prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= {Stages{ResetVal}};
      prev_q  <= ResetVal;
    end else begin
      chain_q <= (chain_q << Width) | ChainW'(d);
      prev_q  <= q;
    end
  end

  assign q    = chain_q[ChainW-1 -: Width];
  assign rise = q & ~prev_q;

endmodule

// File: rtl/dds_pport_responder.sv
// Chip-side responder for the DDS 8-bit parallel register port: shadow/active banks,
// address/data frame decode, read-back drive and the assembled frequency tuning word.
module dds_pport_responder
  import dds_pport_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned FTW_BASE    = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dds_rst_i,
  input  logic              csb_i,
  input  logic              rwn_i,
  input  logic              pclk_i,
  input  logic [7:0]        pd_i,
  output logic [7:0]        pd_o,
  output logic              pd_oe,
  input  logic              io_update_i,
  input  logic [ADDR_W-1:0] act_addr_i,
  output logic [7:0]        act_data_o,
  output logic [31:0]       ftw_o,
  output logic              upd_pulse_o,
  output logic              wr_strobe_o,
  output logic              frame_err_o
);

  localparam int unsigned       Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FtwA3 = ADDR_W'(FTW_BASE + FtwOff31);
  localparam logic [ADDR_W-1:0] FtwA2 = ADDR_W'(FTW_BASE + FtwOff23);
  localparam logic [ADDR_W-1:0] FtwA1 = ADDR_W'(FTW_BASE + FtwOff15);
  localparam logic [ADDR_W-1:0] FtwA0 = ADDR_W'(FTW_BASE + FtwOff7);

  logic [CtrlW-1:0] ctrl_in, ctrl_s, ctrl_rise;
  logic [7:0]       pd_s, pd_unused_rise;

  always_comb begin
    ctrl_in             = '0;
    ctrl_in[CtrlCsbn]   = ~csb_i;
    ctrl_in[CtrlRwn]    = rwn_i;
    ctrl_in[CtrlPclk]   = pclk_i;
    ctrl_in[CtrlUpd]    = io_update_i;
    ctrl_in[CtrlDdsRst] = dds_rst_i;
  end

  dds_pport_sync #(
    .Width   (CtrlW),
    .Stages  (SYNC_STAGES),
    .ResetVal(CtrlRstVal)
  ) u_ctrl_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (ctrl_in),
    .q   (ctrl_s),
    .rise(ctrl_rise)
  );

  dds_pport_sync #(
    .Width   (8),
    .Stages  (SYNC_STAGES),
    .ResetVal(8'h00)
  ) u_pd_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (pd_i),
    .q   (pd_s),
    .rise(pd_unused_rise)
  );

  logic csb_s, csb_fall, rwn_s, pclk_rise, upd_rise, dds_rst_s;
  assign csb_s     = ~ctrl_s[CtrlCsbn];
  assign csb_fall  = ctrl_rise[CtrlCsbn];
  assign rwn_s     = ctrl_s[CtrlRwn];
  assign pclk_rise = ctrl_rise[CtrlPclk];
  assign upd_rise  = ctrl_rise[CtrlUpd];
  assign dds_rst_s = ctrl_s[CtrlDdsRst];

  logic unused_sync;
  assign unused_sync = ^{pd_unused_rise, ctrl_s[CtrlPclk], ctrl_s[CtrlUpd],
                         ctrl_rise[CtrlRwn], ctrl_rise[CtrlDdsRst]};

  pport_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d, addr_ok_q, addr_ok_d;
  logic [7:0]        shadow_q [Depth];
  logic [7:0]        shadow_d [Depth];
  logic [7:0]        act_q [Depth];
  logic [7:0]        act_d [Depth];
  logic [7:0]        rd_data_q, rd_data_d, act_data_q, act_data_d;
  logic [31:0]       ftw_q, ftw_d;
  logic              oe_q, oe_d, upd_q, upd_d, wr_q, wr_d, err_q, err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    addr_ok_d = addr_ok_q;
    wr_d      = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      StIdle: if (csb_fall) state_d = StAddr;
      StAddr: begin
        if (csb_s) begin
          state_d = StIdle;
        end else if (pclk_rise) begin
          addr_d    = pd_s[ADDR_W-1:0];
          rw_d      = rwn_s;
          addr_ok_d = (pd_s >> ADDR_W) == 8'h00;
          err_d     = err_q | ~addr_ok_d;
          state_d   = StData;
        end
      end
      StData: begin
        if (csb_s) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (pclk_rise) begin
          wr_d    = ~rw_q & addr_ok_q;
          state_d = StTail;
        end
      end
      StTail: begin
        if (csb_s) state_d = StIdle;
        else if (pclk_rise) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    shadow_d = shadow_q;
    if (wr_d) shadow_d[addr_q] = pd_s;
    // Copying from shadow_d lets a same-cycle write land in the active bank too.
    act_d = act_q;
    if (upd_rise) act_d = shadow_d;
    upd_d = upd_rise;

    oe_d       = (state_d == StData) && rw_d;
    rd_data_d  = (oe_d && addr_ok_d) ? shadow_q[addr_d] : 8'h00;
    act_data_d = act_q[act_addr_i];
    ftw_d      = {act_q[FtwA3], act_q[FtwA2], act_q[FtwA1], act_q[FtwA0]};

    if (dds_rst_s) begin
      state_d    = StIdle;
      addr_d     = '0;
      rw_d       = 1'b0;
      addr_ok_d  = 1'b0;
      shadow_d   = '{default: 8'h00};
      act_d      = '{default: 8'h00};
      oe_d       = 1'b0;
      rd_data_d  = 8'h00;
      act_data_d = 8'h00;
      ftw_d      = 32'h0;
      upd_d      = 1'b0;
      wr_d       = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      addr_ok_q  <= 1'b0;
      shadow_q   <= '{default: 8'h00};
      act_q      <= '{default: 8'h00};
      oe_q       <= 1'b0;
      rd_data_q  <= 8'h00;
      act_data_q <= 8'h00;
      ftw_q      <= 32'h0;
      upd_q      <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      addr_ok_q  <= addr_ok_d;
      shadow_q   <= shadow_d;
      act_q      <= act_d;
      oe_q       <= oe_d;
      rd_data_q  <= rd_data_d;
      act_data_q <= act_data_d;
      ftw_q      <= ftw_d;
      upd_q      <= upd_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
    end
  end

  assign pd_o        = rd_data_q;
  assign pd_oe       = oe_q;
  assign act_data_o  = act_data_q;
  assign ftw_o       = ftw_q;
  assign upd_pulse_o = upd_q;
  assign wr_strobe_o = wr_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_dds_pport_responder.sv
// Directed bench for dds_pport_responder: frames driven pin-level, expectations hand-computed.
module tb_dds_pport_responder;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       dds_rst_i = 1'b0;
  logic       csb_i = 1'b1;
  logic       rwn_i = 1'b1;
  logic       pclk_i = 1'b0;
  logic [7:0] pd_i = 8'h00;
  logic       io_update_i = 1'b0;
  logic [5:0] act_addr_i = 6'd0;
  logic [7:0] pd_o, act_data_o;
  logic       pd_oe, upd_pulse_o, wr_strobe_o, frame_err_o;
  logic [31:0] ftw_o;

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int upd_cnt = 0;

  dds_pport_responder #(
    .ADDR_W     (6),
    .FTW_BASE   (0),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .dds_rst_i  (dds_rst_i),
    .csb_i      (csb_i),
    .rwn_i      (rwn_i),
    .pclk_i     (pclk_i),
    .pd_i       (pd_i),
    .pd_o       (pd_o),
    .pd_oe      (pd_oe),
    .io_update_i(io_update_i),
    .act_addr_i (act_addr_i),
    .act_data_o (act_data_o),
    .ftw_o      (ftw_o),
    .upd_pulse_o(upd_pulse_o),
    .wr_strobe_o(wr_strobe_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe_o) wr_cnt <= wr_cnt + 1;
    if (upd_pulse_o) upd_cnt <= upd_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full frame; returns bus-drive observations in the address, data-slot and after-data windows.
  task automatic do_frame(input logic rd, input logic [7:0] a, input logic [7:0] dat,
                          input logic upd_with_data, output logic [7:0] rd_data,
                          output logic oe_addr, output logic oe_slot, output logic oe_after);
    csb_i = 1'b0;
    rwn_i = rd;
    tick(4);
    pd_i = a;
    pclk_i = 1'b1;
    tick(1);
    oe_addr = pd_oe;
    tick(3);
    pclk_i = 1'b0;
    tick(4);
    pd_i = dat;
    oe_slot = pd_oe;
    rd_data = pd_o;
    pclk_i = 1'b1;
    if (upd_with_data) io_update_i = 1'b1;
    tick(4);
    oe_after = pd_oe;
    pclk_i = 1'b0;
    io_update_i = 1'b0;
    tick(4);
    csb_i = 1'b1;
    tick(4);
  endtask

  task automatic pulse_update();
    io_update_i = 1'b1;
    tick(4);
    io_update_i = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    tick(3);
    n_vec++;
    if ({pd_o, pd_oe, act_data_o} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got pd_o=%h oe=%b act=%h want 0", pd_o, pd_oe, act_data_o);
    end
    n_vec++;
    if ({ftw_o, upd_pulse_o, wr_strobe_o, frame_err_o} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_flags: got ftw=%h upd=%b wr=%b err=%b want 0",
               ftw_o, upd_pulse_o, wr_strobe_o, frame_err_o);
    end
    rstn = 1'b1;
    tick(4);
  endtask

  task automatic test_ftw();
    logic [7:0] rd;
    logic oa, os, oz;
    int w0, u0;
    w0 = wr_cnt;
    u0 = upd_cnt;
    do_frame(1'b0, 8'h00, 8'h0c, 1'b0, rd, oa, os, oz);
    do_frame(1'b0, 8'h01, 8'hd0, 1'b0, rd, oa, os, oz);
    do_frame(1'b0, 8'h02, 8'h0d, 1'b0, rd, oa, os, oz);
    do_frame(1'b0, 8'h03, 8'h41, 1'b0, rd, oa, os, oz);
    n_vec++;
    if (wr_cnt - w0 !== 4) begin
      n_bad++;
      $display("FAIL ftw_wr_strobes: got %0d want 4", wr_cnt - w0);
    end
    n_vec++;
    if (ftw_o !== 32'h0) begin
      n_bad++;
      $display("FAIL ftw_before_update: got %h want 00000000", ftw_o);
    end
    n_vec++;
    if (upd_cnt - u0 !== 0) begin
      n_bad++;
      $display("FAIL upd_before_update: got %0d want 0", upd_cnt - u0);
    end
    pulse_update();
    n_vec++;
    if (upd_cnt - u0 !== 1) begin
      n_bad++;
      $display("FAIL upd_pulse_count: got %0d want 1", upd_cnt - u0);
    end
    n_vec++;
    if (ftw_o !== 32'h0cd00d41) begin
      n_bad++;
      $display("FAIL ftw_after_update: got %h want 0cd00d41", ftw_o);
    end
  endtask

  task automatic test_read_back();
    logic [7:0] rd;
    logic oa, os, oz;
    int w0;
    w0 = wr_cnt;
    do_frame(1'b0, 8'h05, 8'ha5, 1'b0, rd, oa, os, oz);
    act_addr_i = 6'd5;
    tick(2);
    n_vec++;
    if (act_data_o !== 8'h00) begin
      n_bad++;
      $display("FAIL act5_before_update: got %h want 00", act_data_o);
    end
    do_frame(1'b1, 8'h05, 8'h00, 1'b0, rd, oa, os, oz);
    n_vec++;
    if ({oa, os, oz} !== 3'b010) begin
      n_bad++;
      $display("FAIL read_oe_window: got addr/slot/after=%b%b%b want 010", oa, os, oz);
    end
    n_vec++;
    if (rd !== 8'ha5) begin
      n_bad++;
      $display("FAIL read_data5: got %h want a5", rd);
    end
    n_vec++;
    if (wr_cnt - w0 !== 1) begin
      n_bad++;
      $display("FAIL read_no_strobe: got %0d strobes want 1", wr_cnt - w0);
    end
    pulse_update();
    n_vec++;
    if (act_data_o !== 8'ha5) begin
      n_bad++;
      $display("FAIL act5_after_update: got %h want a5", act_data_o);
    end
  endtask

  task automatic test_same_cycle_update();
    logic [7:0] rd;
    logic oa, os, oz;
    int u0;
    u0 = upd_cnt;
    do_frame(1'b0, 8'h03, 8'h3c, 1'b1, rd, oa, os, oz);
    act_addr_i = 6'd3;
    tick(2);
    n_vec++;
    if (act_data_o !== 8'h3c) begin
      n_bad++;
      $display("FAIL same_cycle_act3: got %h want 3c", act_data_o);
    end
    n_vec++;
    if (ftw_o !== 32'h0cd00d3c) begin
      n_bad++;
      $display("FAIL same_cycle_ftw: got %h want 0cd00d3c", ftw_o);
    end
    n_vec++;
    if (upd_cnt - u0 !== 1) begin
      n_bad++;
      $display("FAIL same_cycle_upd: got %0d want 1", upd_cnt - u0);
    end
  endtask

  task automatic test_bad_addr();
    logic [7:0] rd;
    logic oa, os, oz;
    int w0;
    n_vec++;
    if (frame_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clean_before: got %b want 0", frame_err_o);
    end
    w0 = wr_cnt;
    do_frame(1'b0, 8'h40, 8'h99, 1'b0, rd, oa, os, oz);
    n_vec++;
    if (frame_err_o !== 1'b1 || wr_cnt != w0) begin
      n_bad++;
      $display("FAIL bad_addr_write: got err=%b strobes=%0d want err=1 strobes=0",
               frame_err_o, wr_cnt - w0);
    end
    do_frame(1'b1, 8'h40, 8'h00, 1'b0, rd, oa, os, oz);
    n_vec++;
    if (os !== 1'b1 || rd !== 8'h00) begin
      n_bad++;
      $display("FAIL bad_addr_read: got oe=%b data=%h want oe=1 data=00", os, rd);
    end
    do_frame(1'b1, 8'h00, 8'h00, 1'b0, rd, oa, os, oz);
    n_vec++;
    if (rd !== 8'h0c) begin
      n_bad++;
      $display("FAIL addr0_untouched: got %h want 0c", rd);
    end
  endtask

  task automatic test_dds_rst();
    logic [7:0] rd;
    logic oa, os, oz;
    dds_rst_i = 1'b1;
    tick(4);
    dds_rst_i = 1'b0;
    tick(4);
    n_vec++;
    if ({frame_err_o, pd_oe, act_data_o, ftw_o} !== 42'h0) begin
      n_bad++;
      $display("FAIL dds_rst_outputs: got err=%b oe=%b act=%h ftw=%h want 0",
               frame_err_o, pd_oe, act_data_o, ftw_o);
    end
    do_frame(1'b1, 8'h05, 8'h00, 1'b0, rd, oa, os, oz);
    n_vec++;
    if (rd !== 8'h00) begin
      n_bad++;
      $display("FAIL dds_rst_shadow5: got %h want 00", rd);
    end
    pulse_update();
    n_vec++;
    if (ftw_o !== 32'h0 || act_data_o !== 8'h00) begin
      n_bad++;
      $display("FAIL dds_rst_active: got ftw=%h act=%h want 0", ftw_o, act_data_o);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    logic oa, os, oz;
    int w0;
    w0 = wr_cnt;
    csb_i = 1'b0;
    rwn_i = 1'b0;
    tick(4);
    pd_i = 8'h07;
    pclk_i = 1'b1;
    tick(4);
    pclk_i = 1'b0;
    tick(4);
    pd_i = 8'h11;
    csb_i = 1'b1;
    tick(4);
    n_vec++;
    if (frame_err_o !== 1'b1 || wr_cnt != w0) begin
      n_bad++;
      $display("FAIL abort_err: got err=%b strobes=%0d want err=1 strobes=0",
               frame_err_o, wr_cnt - w0);
    end
    do_frame(1'b1, 8'h07, 8'h00, 1'b0, rd, oa, os, oz);
    n_vec++;
    if (rd !== 8'h00) begin
      n_bad++;
      $display("FAIL abort_shadow7: got %h want 00", rd);
    end
    do_frame(1'b0, 8'h07, 8'h77, 1'b0, rd, oa, os, oz);
    do_frame(1'b1, 8'h07, 8'h00, 1'b0, rd, oa, os, oz);
    n_vec++;
    if (rd !== 8'h77 || wr_cnt - w0 !== 1) begin
      n_bad++;
      $display("FAIL abort_recover: got data=%h strobes=%0d want 77 and 1", rd, wr_cnt - w0);
    end
  endtask

  task automatic test_rstn_mid_frame();
    logic [7:0] rd;
    logic oa, os, oz;
    int w0;
    do_frame(1'b0, 8'h00, 8'hff, 1'b0, rd, oa, os, oz);
    pulse_update();
    act_addr_i = 6'd0;
    tick(2);
    n_vec++;
    if (ftw_o !== 32'hff000000 || act_data_o !== 8'hff) begin
      n_bad++;
      $display("FAIL pre_rstn_state: got ftw=%h act=%h want ff000000 ff", ftw_o, act_data_o);
    end
    w0 = wr_cnt;
    csb_i = 1'b0;
    rwn_i = 1'b0;
    tick(4);
    pd_i = 8'h09;
    pclk_i = 1'b1;
    tick(4);
    pclk_i = 1'b0;
    tick(4);
    pd_i = 8'h55;
    pclk_i = 1'b1;
    tick(1);
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({pd_o, pd_oe, act_data_o, ftw_o, upd_pulse_o, wr_strobe_o, frame_err_o} !== 52'h0) begin
      n_bad++;
      $display("FAIL rstn_async_clear: got pd=%h oe=%b act=%h ftw=%h upd=%b wr=%b err=%b",
               pd_o, pd_oe, act_data_o, ftw_o, upd_pulse_o, wr_strobe_o, frame_err_o);
    end
    tick(2);
    pclk_i = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(4);
    csb_i = 1'b1;
    tick(4);
    n_vec++;
    if (frame_err_o !== 1'b0 || wr_cnt != w0) begin
      n_bad++;
      $display("FAIL rstn_discard: got err=%b strobes=%0d want 0 and 0", frame_err_o, wr_cnt - w0);
    end
    pulse_update();
    n_vec++;
    if (ftw_o !== 32'h0 || act_data_o !== 8'h00) begin
      n_bad++;
      $display("FAIL rstn_banks: got ftw=%h act=%h want 0", ftw_o, act_data_o);
    end
    do_frame(1'b0, 8'h09, 8'h55, 1'b0, rd, oa, os, oz);
    do_frame(1'b1, 8'h09, 8'h00, 1'b0, rd, oa, os, oz);
    n_vec++;
    if (rd !== 8'h55) begin
      n_bad++;
      $display("FAIL rstn_recover: got %h want 55", rd);
    end
  endtask

  initial begin
    test_reset();
    test_ftw();
    test_read_back();
    test_same_cycle_update();
    test_bad_addr();
    test_dds_rst();
    test_abort();
    test_rstn_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
